// File: rtl/req_priority_encoder_if.sv
// Request-in / code-out bundle for the sequential 8-to-3 priority encoder.
// The encoder is the master of the code channel; the consumer/source is the slave.
interface req_priority_encoder_if;
  logic [7:0] req;
  logic [2:0] out_code;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] pending;
  logic       idle;

  modport master (
    input  req,
    input  out_ready,
    output out_code,
    output out_valid,
    output pending,
    output idle
  );

  modport slave (
    output req,
    output out_ready,
    input  out_code,
    input  out_valid,
    input  pending,
    input  idle
  );
endinterface

// File: rtl/req_priority_encoder.sv
// Sequential 8-to-3 encoder: sticky pending register of request lines, one
// binary line index emitted per valid/ready transfer. Fixed priority (bit 7
// wins) or round-robin starting just after the last granted index.
module req_priority_encoder #(
  parameter bit ROUND_ROBIN = 1'b0
) (
  input  logic                         clk,
  input  logic                         rst_n,
  req_priority_encoder_if.master       bus
);

  localparam int NUM_LINES = 8;
  localparam int IDX_W     = 3;

  logic [NUM_LINES-1:0] pending_q, pending_d;
  logic                 out_valid_q, out_valid_d;
  logic [IDX_W-1:0]     out_code_q, out_code_d;
  logic [IDX_W-1:0]     rr_ptr_q, rr_ptr_d;

  logic [IDX_W-1:0]     sel_idx;
  logic [IDX_W-1:0]     cand;
  logic                 load;
  logic [NUM_LINES-1:0] grant_mask;

  // Pick one pending line; looks only at registered pending, never at req.
  always_comb begin
    sel_idx = '0;
    cand    = '0;
    if (ROUND_ROBIN) begin
      // Scan downward from the farthest offset so the nearest set bit at or
      // after rr_ptr is the last assignment; 3-bit add gives the 7->0 wrap.
      for (int k = NUM_LINES-1; k >= 0; k--) begin
        cand = rr_ptr_q + IDX_W'(k);
        if (pending_q[cand]) sel_idx = cand;
      end
    end else begin
      // Ascending scan: highest set index is the one that sticks.
      for (int i = 0; i < NUM_LINES; i++) begin
        if (pending_q[i]) sel_idx = IDX_W'(i);
      end
    end
  end

  // A new code may be loaded whenever something is pending and the output
  // slot is empty or being drained this very cycle.
  always_comb begin
    load = (pending_q != '0) && (!out_valid_q || bus.out_ready);
  end

  // Per-line pending update: clear the granted line, then OR in req so a
  // request arriving on the grant edge keeps the bit set.
  for (genvar g = 0; g < NUM_LINES; g++) begin : g_line
    always_comb begin
      grant_mask[g] = load && (sel_idx == IDX_W'(g));
      pending_d[g]  = (pending_q[g] & ~grant_mask[g]) | bus.req[g];
    end
  end

  // Output slot and round-robin pointer next-state.
  always_comb begin
    out_valid_d = out_valid_q;
    out_code_d  = out_code_q;
    rr_ptr_d    = rr_ptr_q;
    if (load) begin
      out_valid_d = 1'b1;
      out_code_d  = sel_idx;
      rr_ptr_d    = sel_idx + IDX_W'(1);
    end else if (out_valid_q && bus.out_ready) begin
      // Delivered with nothing behind it; code keeps its last value.
      out_valid_d = 1'b0;
    end
  end

  // State registers; reset drops all pending requests and any held grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q   <= '0;
      out_valid_q <= 1'b0;
      out_code_q  <= '0;
      rr_ptr_q    <= '0;
    end else begin
      pending_q   <= pending_d;
      out_valid_q <= out_valid_d;
      out_code_q  <= out_code_d;
      rr_ptr_q    <= rr_ptr_d;
    end
  end

  // Observability and idle, all from registered state.
  always_comb begin
    bus.out_code  = out_code_q;
    bus.out_valid = out_valid_q;
    bus.pending   = pending_q;
    bus.idle      = (pending_q == '0) && !out_valid_q;
  end

endmodule
